rob_commit: RTL and testbench

- 64-entry circular reorder buffer for the 8-register, 16-bit out-of-order core.
- Allocates up to 2 tags per cycle at dispatch and accepts up to 2 completions per cycle from functional units.
- Retires up to 2 finished instructions per cycle in program order.
- Commit outputs drive the register file's two write ports (wen/waddr/wdata) directly; commit tags let rename logic clear busy/rob_loc.

---
 rtl/rob_commit.sv | 244 ++++++++++++++++++++++++
 tb/tb_rob_commit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// 64-entry reorder buffer: dual dispatch, dual writeback, in-order dual retire.
// Define ROB_PERF_EN to add the committed_cnt retired-instruction counter.
module rob_commit #(
  parameter int DEPTH  = 64,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alloc0_valid,
  input  logic              alloc0_has_dest,
  input  logic [REG_W-1:0]  alloc0_dest,
  input  logic              alloc1_valid,
  input  logic              alloc1_has_dest,
  input  logic [REG_W-1:0]  alloc1_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag0,
  output logic [TAG_W-1:0]  alloc_tag1,
  input  logic              wb0_valid,
  input  logic [TAG_W-1:0]  wb0_tag,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb1_valid,
  input  logic [TAG_W-1:0]  wb1_tag,
  input  logic [DATA_W-1:0] wb1_data,
  input  logic [TAG_W-1:0]  q0_tag,
  output logic              q0_done,
  output logic [DATA_W-1:0] q0_data,
  input  logic [TAG_W-1:0]  q1_tag,
  output logic              q1_done,
  output logic [DATA_W-1:0] q1_data,
  output logic              wen0,
  output logic [REG_W-1:0]  waddr0,
  output logic [DATA_W-1:0] wdata0,
  output logic              wen1,
  output logic [REG_W-1:0]  waddr1,
  output logic [DATA_W-1:0] wdata1,
  output logic              commit0_valid,
  output logic [TAG_W-1:0]  commit0_tag,
  output logic              commit1_valid,
  output logic [TAG_W-1:0]  commit1_tag,
  output logic              empty
`ifdef ROB_PERF_EN
  ,
  output logic [31:0]       committed_cnt
`endif
);

  localparam int CW = TAG_W + 1;

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic              valid;
    tag_t              tag;
    logic              wen;
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } cmt_t;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [DEPTH-1:0]  hdst_q, hdst_d;
  logic [REG_W-1:0]  dest_q [DEPTH];
  logic [REG_W-1:0]  dest_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  tag_t          head_q, head_d;
  tag_t          tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  cmt_t cmt0_q, cmt0_d;
  cmt_t cmt1_q, cmt1_d;

  tag_t       head1;
  tag_t       tail1;
  logic       do_a0;
  logic       do_a1;
  logic       ret0;
  logic       ret1;
  logic [1:0] n_alloc;
  logic [1:0] n_ret;

  assign head1 = head_q + tag_t'(1);
  assign tail1 = tail_q + tag_t'(1);

  assign alloc_ready = (count_q <= CW'(DEPTH - 2));
  assign alloc_tag0  = tail_q;
  assign alloc_tag1  = tail1;
  assign empty       = (count_q == '0);

  assign do_a0 = alloc_ready & alloc0_valid & ~flush;
  assign do_a1 = do_a0 & alloc1_valid;

  // Retire decisions see pre-edge done bits, so a same-edge writeback waits.
  assign ret0 = ~flush & valid_q[head_q] & done_q[head_q];
  assign ret1 = ret0 & valid_q[head1] & done_q[head1];

  assign n_alloc = {1'b0, do_a0} + {1'b0, do_a1};
  assign n_ret   = {1'b0, ret0} + {1'b0, ret1};

  assign q0_done = valid_q[q0_tag] & done_q[q0_tag];
  assign q0_data = data_q[q0_tag];
  assign q1_done = valid_q[q1_tag] & done_q[q1_tag];
  assign q1_data = data_q[q1_tag];

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    hdst_d  = hdst_q;
    dest_d  = dest_q;
    data_d  = data_q;

    if (wb0_valid && valid_q[wb0_tag]) begin
      done_d[wb0_tag] = 1'b1;
      data_d[wb0_tag] = wb0_data;
    end
    if (wb1_valid && valid_q[wb1_tag]) begin
      done_d[wb1_tag] = 1'b1;
      data_d[wb1_tag] = wb1_data;
    end

    if (ret0) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
    end
    if (ret1) begin
      valid_d[head1] = 1'b0;
      done_d[head1]  = 1'b0;
    end

    // Allocation only targets free slots, never ones retiring this edge.
    if (do_a0) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      hdst_d[tail_q]  = alloc0_has_dest;
      dest_d[tail_q]  = alloc0_dest;
    end
    if (do_a1) begin
      valid_d[tail1] = 1'b1;
      done_d[tail1]  = 1'b0;
      hdst_d[tail1]  = alloc1_has_dest;
      dest_d[tail1]  = alloc1_dest;
    end

    if (flush) begin
      valid_d = '0;
      done_d  = '0;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case (1'b1)
      flush: begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
      default: begin
        head_d  = head_q + tag_t'(n_ret);
        tail_d  = tail_q + tag_t'(n_alloc);
        count_d = count_q + CW'(n_alloc) - CW'(n_ret);
      end
    endcase
  end

  always_comb begin
    cmt0_d = '0;
    cmt1_d = '0;
    if (ret0) begin
      cmt0_d.valid = 1'b1;
      cmt0_d.tag   = head_q;
      cmt0_d.wen   = hdst_q[head_q];
      cmt0_d.addr  = dest_q[head_q];
      cmt0_d.data  = data_q[head_q];
    end
    if (ret1) begin
      cmt1_d.valid = 1'b1;
      cmt1_d.tag   = head1;
      cmt1_d.wen   = hdst_q[head1];
      cmt1_d.addr  = dest_q[head1];
      cmt1_d.data  = data_q[head1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      done_q  <= '0;
      hdst_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      cmt0_q  <= '0;
      cmt1_q  <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      hdst_q  <= hdst_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cmt0_q  <= cmt0_d;
      cmt1_q  <= cmt1_d;
    end
  end

  assign commit0_valid = cmt0_q.valid;
  assign commit0_tag   = cmt0_q.tag;
  assign wen0          = cmt0_q.wen;
  assign waddr0        = cmt0_q.addr;
  assign wdata0        = cmt0_q.data;
  assign commit1_valid = cmt1_q.valid;
  assign commit1_tag   = cmt1_q.tag;
  assign wen1          = cmt1_q.wen;
  assign waddr1        = cmt1_q.addr;
  assign wdata1        = cmt1_q.data;

`ifdef ROB_PERF_EN
  logic [31:0] cnt_q, cnt_d;

  // Flush does not clear it; only reset does.
  assign cnt_d = cnt_q + 32'(n_ret);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign committed_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: dispatch, writeback, retire, fill,
// wrap-around, flush and no-destination commits.
module tb_rob_commit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        alloc0_valid, alloc0_has_dest;
  logic [2:0]  alloc0_dest;
  logic        alloc1_valid, alloc1_has_dest;
  logic [2:0]  alloc1_dest;
  logic        alloc_ready;
  logic [5:0]  alloc_tag0, alloc_tag1;
  logic        wb0_valid, wb1_valid;
  logic [5:0]  wb0_tag, wb1_tag;
  logic [15:0] wb0_data, wb1_data;
  logic [5:0]  q0_tag, q1_tag;
  logic        q0_done, q1_done;
  logic [15:0] q0_data, q1_data;
  logic        wen0, wen1;
  logic [2:0]  waddr0, waddr1;
  logic [15:0] wdata0, wdata1;
  logic        commit0_valid, commit1_valid;
  logic [5:0]  commit0_tag, commit1_tag;
  logic        empty;
`ifdef ROB_PERF_EN
  logic [31:0] committed_cnt;
`endif

  int checks = 0;
  int errors = 0;

  rob_commit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc0_valid(alloc0_valid), .alloc0_has_dest(alloc0_has_dest),
    .alloc0_dest(alloc0_dest),
    .alloc1_valid(alloc1_valid), .alloc1_has_dest(alloc1_has_dest),
    .alloc1_dest(alloc1_dest),
    .alloc_ready(alloc_ready),
    .alloc_tag0(alloc_tag0), .alloc_tag1(alloc_tag1),
    .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_data(wb1_data),
    .q0_tag(q0_tag), .q0_done(q0_done), .q0_data(q0_data),
    .q1_tag(q1_tag), .q1_done(q1_done), .q1_data(q1_data),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .commit0_valid(commit0_valid), .commit0_tag(commit0_tag),
    .commit1_valid(commit1_valid), .commit1_tag(commit1_tag),
    .empty(empty)
`ifdef ROB_PERF_EN
    , .committed_cnt(committed_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int exp);
`ifdef ROB_PERF_EN
    chk(tag, committed_cnt, exp);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0;
    alloc0_valid = 0; alloc0_has_dest = 0; alloc0_dest = 0;
    alloc1_valid = 0; alloc1_has_dest = 0; alloc1_dest = 0;
    wb0_valid = 0; wb0_tag = 0; wb0_data = 0;
    wb1_valid = 0; wb1_tag = 0; wb1_data = 0;
  endtask

  task automatic alloc(input logic v1, input logic [2:0] d0,
                       input logic [2:0] d1);
    alloc0_valid = 1; alloc0_has_dest = 1; alloc0_dest = d0;
    alloc1_valid = v1; alloc1_has_dest = 1; alloc1_dest = d1;
  endtask

  task automatic wb(input logic v0, input logic [5:0] t0,
                    input logic [15:0] d0, input logic v1,
                    input logic [5:0] t1, input logic [15:0] d1);
    wb0_valid = v0; wb0_tag = t0; wb0_data = d0;
    wb1_valid = v1; wb1_tag = t1; wb1_data = d1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    #1;
    chk("rst_ready", alloc_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_tag0", alloc_tag0, 0);
    chk("rst_c0v", commit0_valid, 0);
    chk("rst_c1v", commit1_valid, 0);
    chk("rst_wen0", wen0, 0);
    chk("rst_wdata0", wdata0, 0);
    chk_cnt("rst_cnt", 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 1;
    q0_tag = 0; q1_tag = 0;
    idle();
    #1;
    do_reset();

    // Dual alloc, dual writeback, dual commit.
    alloc(1, 3'd1, 3'd2);
    chk("t1_tag0", alloc_tag0, 0);
    chk("t1_tag1", alloc_tag1, 1);
    step();
    idle();
    wb(1, 6'd0, 16'h1234, 1, 6'd1, 16'hBEEF);
    q0_tag = 0;
    #1;
    chk("t1_nobypass", q0_done, 0);
    step();
    idle();
    #1;
    chk("t1_qdone", q0_done, 1);
    chk("t1_qdata", q0_data, 16'h1234);
    step();
    chk("t1_wen0", wen0, 1);
    chk("t1_waddr0", waddr0, 1);
    chk("t1_wdata0", wdata0, 16'h1234);
    chk("t1_wen1", wen1, 1);
    chk("t1_waddr1", waddr1, 2);
    chk("t1_wdata1", wdata1, 16'hBEEF);
    chk("t1_ctag0", commit0_tag, 0);
    chk("t1_ctag1", commit1_tag, 1);
    chk("t1_empty", empty, 1);
    chk_cnt("t1_cnt", 2);
    step();
    chk("t1_c0v_off", commit0_valid, 0);
    chk("t1_wen1_off", wen1, 0);

    do_reset();

    // Out-of-order completion; wb1 wins on a shared tag.
    alloc(1, 3'd3, 3'd4);
    step();
    alloc(0, 3'd5, 3'd0);
    chk("t2_tag0", alloc_tag0, 2);
    step();
    idle();
    wb(1, 6'd2, 16'hDEAD, 1, 6'd2, 16'h2222);
    step();
    wb(1, 6'd1, 16'h1111, 0, 6'd0, 16'h0);
    q1_tag = 2;
    #1;
    chk("t2_wb1wins_done", q1_done, 1);
    chk("t2_wb1wins_data", q1_data, 16'h2222);
    step();
    chk("t2_nocommit_a", commit0_valid, 0);
    idle();
    step();
    chk("t2_nocommit_b", commit0_valid, 0);
    wb(1, 6'd0, 16'h0AAA, 0, 6'd0, 16'h0);
    step();
    chk("t2_wb_head_same_edge", commit0_valid, 0);
    idle();
    step();
    chk("t2_c0v", commit0_valid, 1);
    chk("t2_c0tag", commit0_tag, 0);
    chk("t2_waddr0", waddr0, 3);
    chk("t2_wdata0", wdata0, 16'h0AAA);
    chk("t2_c1v", commit1_valid, 1);
    chk("t2_c1tag", commit1_tag, 1);
    chk("t2_waddr1", waddr1, 4);
    chk("t2_wdata1", wdata1, 16'h1111);
    step();
    chk("t2_c0v_b", commit0_valid, 1);
    chk("t2_c0tag_b", commit0_tag, 2);
    chk("t2_waddr0_b", waddr0, 5);
    chk("t2_wdata0_b", wdata0, 16'h2222);
    chk("t2_c1v_b", commit1_valid, 0);
    chk("t2_wen1_b", wen1, 0);
    chk_cnt("t2_cnt", 3);
    step();
    chk("t2_c0v_off", commit0_valid, 0);
    chk("t2_empty", empty, 1);

    // Entry without a destination still retires.
    alloc0_valid = 1; alloc0_has_dest = 0; alloc0_dest = 3'd6;
    chk("t6_tag0", alloc_tag0, 3);
    step();
    idle();
    wb(1, 6'd3, 16'h5555, 0, 6'd0, 16'h0);
    step();
    idle();
    step();
    chk("t6_c0v", commit0_valid, 1);
    chk("t6_c0tag", commit0_tag, 3);
    chk("t6_wen0", wen0, 0);
    chk("t6_waddr0", waddr0, 6);
    chk("t6_wdata0", wdata0, 16'h5555);
    chk_cnt("t6_cnt", 4);

    do_reset();

    // Fill to 64 entries; extra request is dropped.
    for (int i = 0; i < 31; i++) begin
      alloc(1, 3'(i), 3'(i + 1));
      chk("t3_ready", alloc_ready, 1);
      chk("t3_tag0", alloc_tag0, 2 * i);
      step();
    end
    chk("t3_ready62", alloc_ready, 1);
    chk("t3_tag0_62", alloc_tag0, 62);
    chk("t3_tag1_62", alloc_tag1, 63);
    step();
    chk("t3_ready64", alloc_ready, 0);
    chk("t3_full_tag0", alloc_tag0, 0);
    chk("t3_full_notempty", empty, 0);
    step();
    chk("t3_drop_tag0", alloc_tag0, 0);
    chk("t3_drop_tag1", alloc_tag1, 1);
    chk("t3_drop_ready", alloc_ready, 0);
    chk("t3_no_commit", commit0_valid, 0);

    do_reset();

    // Walk head/tail to 63, then dual alloc and commit across the wrap.
    for (int i = 0; i < 31; i++) begin
      alloc(1, 3'd1, 3'd2);
      step();
    end
    alloc(0, 3'd1, 3'd0);
    step();
    idle();
    for (int i = 0; i < 32; i++) begin
      wb(1, 6'(2 * i), 16'(i), (i < 31), 6'(2 * i + 1), 16'(i));
      step();
    end
    idle();
    for (int k = 0; k < 8 && !empty; k++) step();
    chk("t4_drained", empty, 1);
    chk_cnt("t4_cnt63", 63);
    chk("t4_tag0", alloc_tag0, 63);
    chk("t4_tag1", alloc_tag1, 0);
    alloc(1, 3'd6, 3'd7);
    step();
    idle();
    wb(1, 6'd63, 16'h6363, 1, 6'd0, 16'h0F0F);
    step();
    idle();
    step();
    chk("t4_c0v", commit0_valid, 1);
    chk("t4_c0tag", commit0_tag, 63);
    chk("t4_wdata0", wdata0, 16'h6363);
    chk("t4_waddr0", waddr0, 6);
    chk("t4_c1v", commit1_valid, 1);
    chk("t4_c1tag", commit1_tag, 0);
    chk("t4_wdata1", wdata1, 16'h0F0F);
    chk("t4_waddr1", waddr1, 7);
    chk_cnt("t4_cnt65", 65);
    step();
    chk("t4_empty", empty, 1);
    chk("t4_next_tag", alloc_tag0, 1);

    do_reset();

    // Flush with five pending entries, a head writeback and an alloc.
    alloc(1, 3'd1, 3'd2);
    step();
    alloc(1, 3'd3, 3'd4);
    step();
    alloc(0, 3'd5, 3'd0);
    step();
    idle();
    chk("t5_pending", empty, 0);
    chk("t5_tag0", alloc_tag0, 5);
    flush = 1;
    wb(1, 6'd0, 16'h7777, 0, 6'd0, 16'h0);
    alloc0_valid = 1; alloc0_has_dest = 1; alloc0_dest = 3'd6;
    step();
    idle();
    q0_tag = 0;
    #1;
    chk("t5_c0v", commit0_valid, 0);
    chk("t5_c1v", commit1_valid, 0);
    chk("t5_wen0", wen0, 0);
    chk("t5_empty", empty, 1);
    chk("t5_tag0_after", alloc_tag0, 0);
    chk("t5_q0done", q0_done, 0);
    wb(1, 6'd5, 16'h4444, 0, 6'd0, 16'h0);
    q1_tag = 5;
    step();
    idle();
    chk("t5_wb_invalid", q1_done, 0);
    chk("t5_c0v_b", commit0_valid, 0);
    alloc(0, 3'd7, 3'd0);
    step();
    idle();
    wb(1, 6'd0, 16'h1357, 0, 6'd0, 16'h0);
    step();
    idle();
    step();
    chk("t5_new_c0v", commit0_valid, 1);
    chk("t5_new_tag", commit0_tag, 0);
    chk("t5_new_waddr", waddr0, 7);
    chk("t5_new_wdata", wdata0, 16'h1357);
    chk_cnt("t5_cnt", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
